// File: rtl/batchnorm_relu_3.sv
// Batch-norm + ReLU + requantise stage after dense_3: per-channel scale/shift, clamp, pack N channels.
// Optional macro BNR_ROUND_EN: round-half-up on requantisation (undefined: truncate toward -inf).
module batchnorm_relu_3 #(
  parameter int N       = 32,
  parameter int ACC_W   = 16,
  parameter int SCALE_W = 8,
  parameter int SHIFT_W = 16,
  parameter int OUT_W   = 6,
  localparam int CW     = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ACC_W-1:0]   in_data,
  input  logic               in_last,
  input  logic               coef_we,
  input  logic [CW-1:0]      coef_addr,
  input  logic [SCALE_W-1:0] coef_scale,
  input  logic [SHIFT_W-1:0] coef_shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*OUT_W-1:0] out_data,
  output logic               err_frame
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never waits on ready, and out_data is held stable while out_valid && !out_ready.

  localparam int ACC_FRAC   = 6;
  localparam int SCALE_FRAC = 5;
  localparam int OUT_FRAC   = 3;
  localparam int DROP       = ACC_FRAC + SCALE_FRAC - OUT_FRAC;
  localparam int PROD_W     = ACC_W + SCALE_W;
  localparam int SUM_W      = PROD_W + 1;
  localparam int RQ_W       = SUM_W + 1;
  localparam logic [CW-1:0]    LAST_CH = CW'(N - 1);
  localparam logic [OUT_W-1:0] MAXV    = {1'b0, {(OUT_W-1){1'b1}}};
`ifdef BNR_ROUND_EN
  localparam logic signed [RQ_W-1:0] RND = RQ_W'(2 ** (DROP - 1));
`else
  localparam logic signed [RQ_W-1:0] RND = '0;
`endif

  logic signed [SCALE_W-1:0] scale_mem [N];
  logic signed [SHIFT_W-1:0] shift_mem [N];

  logic [CW-1:0]            cnt;
  logic                     hs;
  logic signed [ACC_W-1:0]  din_s;
  logic signed [PROD_W-1:0] prod_c;

  logic                     s1_valid;
  logic [CW-1:0]            s1_cnt;
  logic signed [PROD_W-1:0] s1_prod;

  logic signed [SUM_W-1:0]  sum_c;
  logic signed [RQ_W-1:0]   rq_c;
  logic signed [RQ_W-1:0]   shr_c;
  logic [OUT_W-1:0]         elem;
  logic [N*OUT_W-1:0]       pack_q;
  logic [N*OUT_W-1:0]       pack_next;
  logic                     load;

  // Stall only the last channel, so a completing frame always finds the output register free.
  assign in_ready = !(cnt == LAST_CH && out_valid && !out_ready);
  assign hs       = in_valid && in_ready;

  assign din_s  = $signed(in_data);
  assign prod_c = PROD_W'(din_s) * PROD_W'(scale_mem[cnt]);

  assign sum_c = SUM_W'(s1_prod) + SUM_W'(shift_mem[s1_cnt]);
  assign rq_c  = RQ_W'(sum_c) + RND;
  assign shr_c = rq_c >>> DROP;

  always_comb begin
    elem = '0;
    if (shr_c[RQ_W-1]) begin
      elem = '0;
    end else if (|shr_c[RQ_W-2:OUT_W-1]) begin
      elem = MAXV;
    end else begin
      elem = shr_c[OUT_W-1:0];
    end
  end

  // The last element bypasses the pack register straight into the output vector.
  always_comb begin
    pack_next = pack_q;
    pack_next[s1_cnt*OUT_W +: OUT_W] = elem;
  end

  assign load = s1_valid && (s1_cnt == LAST_CH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      s1_valid  <= 1'b0;
      s1_cnt    <= '0;
      s1_prod   <= '0;
      pack_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err_frame <= 1'b0;
    end else begin
      s1_valid <= hs;
      if (hs) begin
        s1_cnt  <= cnt;
        s1_prod <= prod_c;
        cnt     <= (in_last || cnt == LAST_CH) ? '0 : cnt + 1'b1;
        if (in_last != (cnt == LAST_CH)) begin
          err_frame <= 1'b1;
        end
      end
      if (s1_valid) begin
        pack_q <= pack_next;
      end
      if (load) begin
        out_data  <= pack_next;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        scale_mem[k] <= SCALE_W'(2 ** SCALE_FRAC);
        shift_mem[k] <= '0;
      end
    end else if (coef_we) begin
      scale_mem[coef_addr] <= $signed(coef_scale);
      shift_mem[coef_addr] <= $signed(coef_shift);
    end
  end

endmodule
